// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - handshaked EX-stage ALU with iterative RV32M multiply/divide
module alu_seq_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5,
    parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_next;

    logic [2*W-1:0] acc;
    logic [W-1:0]   operand;
    logic [CW-1:0]  counter;
    logic [1:0]     sub;
    logic           div_op, neg_q, neg_r;

    // LSB-first shift-add: the multiplier sits in the low half and drains out as the product fills in.
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] a, input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a[2*W-1:W]} + (a[0] ? {1'b0, m} : {(W+1){1'b0}});
        return {s, a[W-1:1]};
    endfunction

    // Restoring divide: remainder in the high half, dividend shifts out while quotient bits shift in.
    function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] a, input logic [W-1:0] d);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         qb;
        t  = {a[2*W-1:W], a[W-1]};
        qb = (t >= {1'b0, d});
        r  = qb ? W'(t - {1'b0, d}) : t[W-1:0];
        return {r, a[W-2:0], qb};
    endfunction

    logic [4:0]             code;
    logic                   code_ok, is_mul, is_div, special, accept;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W-1:0]           alu_res, ma, mb, fix_res;
    logic                   a_signed, b_signed, a_neg, b_neg;
    logic [2*W-1:0]         prod;
    logic [W-1:0]           qf, rf;

    assign code     = Operation[4:0];
    assign code_ok  = ((Operation >> 5) == '0);
    assign is_mul   = code_ok && code[4:3] == 2'b10 && !code[2];
    assign is_div   = code_ok && code[4:3] == 2'b10 && code[2];
    assign shamt    = SrcB[SHAMT_WIDTH-1:0];
    assign in_ready = !reset && state == IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = state != IDLE;

    always_comb begin
        alu_res = '0;
        special = 1'b0;
        if (code_ok) begin
            case (code)
                5'b00000: alu_res = SrcA & SrcB;
                5'b00001: alu_res = SrcA | SrcB;
                5'b00010: alu_res = SrcA + SrcB;
                5'b00011: alu_res = SrcA - SrcB;
                5'b00100: alu_res = SrcA ^ SrcB;
                5'b00101: alu_res = SrcA << shamt;
                5'b00110: alu_res = SrcA >> shamt;
                5'b00111: alu_res = W'($signed(SrcA) < $signed(SrcB));
                5'b01000: alu_res = W'(SrcA == SrcB);
                5'b01001: alu_res = $signed(SrcA) >>> shamt;
                5'b01010: alu_res = W'(SrcA != SrcB);
                5'b01011: alu_res = W'($signed(SrcA) < $signed(SrcB));
                5'b01100: alu_res = W'($signed(SrcA) >= $signed(SrcB));
                5'b01101: alu_res = W'(SrcA < SrcB);
                5'b01110: alu_res = W'(SrcA >= SrcB);
                5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                    if (SrcB == '0) begin
                        special = 1'b1;
                        alu_res = code[1] ? SrcA : '1;
                    end else if (!code[0] && SrcA == MIN_VAL && SrcB == '1) begin
                        special = 1'b1;
                        alu_res = code[1] ? '0 : MIN_VAL;
                    end
                end
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        a_signed = is_div ? !code[0] : (code[1:0] == 2'b01 || code[1:0] == 2'b10);
        b_signed = is_div ? !code[0] : (code[1:0] == 2'b01);
        a_neg    = a_signed && SrcA[W-1];
        b_neg    = b_signed && SrcB[W-1];
        ma       = a_neg ? -SrcA : SrcA;
        mb       = b_neg ? -SrcB : SrcB;
    end

    always_comb begin
        prod    = neg_q ? -acc : acc;
        qf      = neg_q ? -acc[W-1:0] : acc[W-1:0];
        rf      = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (div_op)
            fix_res = sub[1] ? rf : qf;
        else
            fix_res = (sub == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)                 state_next = MUL;
                else if (accept && is_div && !special) state_next = DIV;
            end
            MUL, DIV: if (counter == CW'(W-2)) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The accept edge already performs the first step so total latency lands on DATA_WIDTH+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            operand   <= '0;
            counter   <= '0;
            sub       <= '0;
            div_op    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            ALUResult <= '0;
        end else begin
            counter <= '0;
            case (state)
                MUL: begin
                    acc     <= mul_step(acc, operand);
                    counter <= counter + 1'b1;
                end
                DIV: begin
                    acc     <= div_step(acc, operand);
                    counter <= counter + 1'b1;
                end
                IDLE: begin
                    if (accept && (is_mul || (is_div && !special))) begin
                        sub    <= code[1:0];
                        div_op <= is_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (is_mul) begin
                            acc     <= mul_step({{W{1'b0}}, mb}, ma);
                            operand <= ma;
                        end else begin
                            acc     <= div_step({{W{1'b0}}, ma}, mb);
                            operand <= mb;
                        end
                    end
                end
                default: ;
            endcase

            if (state == FIX) begin
                ALUResult <= fix_res;
                out_valid <= 1'b1;
            end else if (accept && !is_mul && (!is_div || special)) begin
                ALUResult <= alu_res;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
